seq_signed_multiplier: RTL and testbench

Parametrised, iterative signed/unsigned multiplier. It is the sequential successor to the combinational 5x5 array multiplier in the CA datapath. Operands are converted to magnitudes, multiplied by a WIDTH-cycle shift-add loop, and sign-corrected, all under a start/busy/done handshake. One shared adder replaces the NxN cell array, so WIDTH scales without area blow-up, and the result is held until the next completion.

---
 rtl/seq_signed_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_signed_multiplier.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_multiplier.sv
// seq_signed_multiplier
//   Iterative signed/unsigned multiplier. Operands are captured as magnitudes,
//   multiplied by a WIDTH-step shift-add loop sharing a single adder, and the
//   sign is applied in a final fix-up step. The product is held until the
//   next completion.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   signed_mode  1: operands are two's complement, 0: unsigned
//   x, y         multiplicand / multiplier (WIDTH bits), captured with start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when product has been updated
//   product      2*WIDTH-bit result, held between completions
module seq_signed_multiplier #(
  parameter int WIDTH = 5,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_reg,   state_next;
  logic [2*WIDTH-1:0]   acc_reg,     acc_next;
  logic [WIDTH-1:0]     mag_x_reg,   mag_x_next;
  logic [WIDTH-1:0]     mag_y_reg,   mag_y_next;
  logic [CNT_W-1:0]     cnt_reg,     cnt_next;
  logic                 neg_reg,     neg_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic                 done_reg,    done_next;

  // The one shared adder: upper half of the accumulator plus the (gated)
  // multiplicand magnitude, with the carry kept as bit WIDTH.
  logic [WIDTH:0]       sum;

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    mag_x_next   = mag_x_reg;
    mag_y_next   = mag_y_reg;
    cnt_next     = cnt_reg;
    neg_next     = neg_reg;
    product_next = product_reg;
    done_next    = 1'b0;
    sum          = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   (mag_y_reg[0] ? {1'b0, mag_x_reg} : {(WIDTH+1){1'b0}});

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          // Magnitudes are kept as unsigned WIDTH-bit values, so the most
          // negative operand (e.g. -16 for WIDTH=5) maps exactly to 2^(W-1).
          mag_x_next = (signed_mode && x[WIDTH-1]) ? (~x + ONE_W) : x;
          mag_y_next = (signed_mode && y[WIDTH-1]) ? (~y + ONE_W) : y;
          neg_next   = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
          acc_next   = '0;
          cnt_next   = '0;
        end
      end

      CALC: begin
        // Shift {carry, acc} right by one; the carry lands in the MSB.
        acc_next   = {sum, acc_reg[WIDTH-1:1]};
        mag_y_next = mag_y_reg >> 1;
        cnt_next   = cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_LAST) begin
          state_next = FIX;
        end
      end

      FIX: begin
        product_next = neg_reg ? (~acc_reg + ONE_2W) : acc_reg;
        done_next    = 1'b1;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mag_x_reg   <= '0;
      mag_y_reg   <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      mag_x_reg   <= mag_x_next;
      mag_y_reg   <= mag_y_next;
      cnt_reg     <= cnt_next;
      neg_reg     <= neg_next;
      product_reg <= product_next;
      done_reg    <= done_next;
    end
  end

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Testbench for seq_signed_multiplier: a WIDTH=5 and a WIDTH=8 instance.
// Expected products are queued when an operation is issued; monitors pop and
// compare whenever an instance pulses done.
module tb_seq_signed_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=5 instance
  logic        start5, sm5, busy5, done5;
  logic [4:0]  x5, y5;
  logic [9:0]  product5;
  // WIDTH=8 instance
  logic        start8, sm8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] product8;

  seq_signed_multiplier #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(sm5),
    .x(x5), .y(y5), .busy(busy5), .done(done5), .product(product5)
  );

  seq_signed_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .product(product8)
  );

  int total  = 0;
  int passed = 0;

  logic [9:0]  q5[$];
  logic [15:0] q8[$];
  logic [9:0]  e5;
  logic [15:0] e8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done5 === 1'b1) begin
      if (q5.size() == 0) begin
        total++;
        $display("FAIL dut5_spurious_done: got done with product %0h, expected no done", product5);
      end else begin
        e5 = q5.pop_front();
        check("dut5_product", 64'(product5), 64'(e5));
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL dut8_spurious_done: got done with product %0h, expected no done", product8);
      end else begin
        e8 = q8.pop_front();
        check("dut8_product", 64'(product8), 64'(e8));
      end
    end
  end

  task automatic run5(input logic sm, input logic [4:0] a, input logic [4:0] b, input logic [9:0] e);
    int lat, bcnt;
    @(negedge clk);
    sm5 = sm; x5 = a; y5 = b; start5 = 1'b1;
    q5.push_back(e);
    @(negedge clk);
    start5 = 1'b0;
    lat = 1; bcnt = 0;
    if (busy5) bcnt++;
    while (done5 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy5) bcnt++;
    end
    $display("dut5 op sm=%0d x=%0h y=%0h expect=%0h latency=%0d", sm, a, b, e, lat);
    check("dut5_latency", 64'(lat), 64'd7);
    check("dut5_busy_cycles", 64'(bcnt), 64'd6);
  endtask

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int lat, bcnt;
    @(negedge clk);
    sm8 = sm; x8 = a; y8 = b; start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    lat = 1; bcnt = 0;
    if (busy8) bcnt++;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
    end
    $display("dut8 op sm=%0d x=%0h y=%0h expect=%0h latency=%0d", sm, a, b, e, lat);
    check("dut8_latency", 64'(lat), 64'd10);
    check("dut8_busy_cycles", 64'(bcnt), 64'd9);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] ra, rb;
  logic       rsm;
  int         pa, pb;

  initial begin
    rst_n = 1'b0;
    start5 = 1'b0; sm5 = 1'b0; x5 = '0; y5 = '0;
    start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(negedge clk);
    check("reset_product5", 64'(product5), 64'd0);
    check("reset_busy5",    64'(busy5),    64'd0);
    check("reset_done5",    64'(done5),    64'd0);
    check("reset_product8", 64'(product8), 64'd0);
    check("reset_busy8",    64'(busy8),    64'd0);
    rst_n = 1'b1;

    // Directed WIDTH=5 vectors
    run5(1'b1, 5'd7,  5'h1D, 10'h3EB);  //  7 * -3  = -21
    run5(1'b1, 5'h10, 5'h10, 10'h100);  // -16 * -16 = 256
    run5(1'b1, 5'h10, 5'h0F, 10'h310);  // -16 * 15 = -240
    run5(1'b1, 5'h00, 5'h1B, 10'h000);  //  0 * -5   = 0
    run5(1'b0, 5'h1F, 5'h1F, 10'h3C1);  //  31 * 31  = 961
    run5(1'b1, 5'h1F, 5'h1F, 10'h001);  //  -1 * -1  = 1
    run5(1'b1, 5'h0F, 5'h0F, 10'h0E1);  //  15 * 15  = 225
    run5(1'b1, 5'h1F, 5'h05, 10'h3FB);  //  -1 * 5   = -5
    run5(1'b0, 5'h10, 5'h03, 10'h030);  //  16 * 3   = 48
    run5(1'b0, 5'h00, 5'h1F, 10'h000);  //  0 * 31   = 0

    // Handshake: start held through busy is ignored; start in done cycle accepted
    @(negedge clk);
    sm5 = 1'b1; x5 = 5'd7; y5 = 5'h1D; start5 = 1'b1;
    q5.push_back(10'h3EB);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      sm5 = 1'b0; x5 = 5'd1; y5 = 5'd1; start5 = 1'b1;
    end
    @(negedge clk);
    check("hs_first_done", 64'(done5), 64'd1);
    sm5 = 1'b0; x5 = 5'd3; y5 = 5'd2; start5 = 1'b1;
    q5.push_back(10'h006);
    @(negedge clk);
    start5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("hs_product_held", 64'(product5), 64'h3EB);
      check("hs_no_early_done", 64'(done5), 64'd0);
      @(negedge clk);
    end
    check("hs_second_done", 64'(done5), 64'd1);
    $display("dut5 handshake op x=3 y=2 expect=006 done at cycle 7");

    // Directed WIDTH=8 vectors
    run8(1'b1, 8'h80, 8'h80, 16'h4000); // -128 * -128 = 16384
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01); // 255 * 255 = 65025
    run8(1'b1, 8'h7F, 8'h80, 16'hC080); // 127 * -128 = -16256
    run8(1'b0, 8'hC8, 8'h03, 16'h0258); // 200 * 3 = 600
    run8(1'b1, 8'hFF, 8'hFF, 16'h0001); // -1 * -1 = 1

    // Asynchronous reset mid-operation (dut8 idle, product nonzero)
    @(negedge clk);
    sm5 = 1'b0; x5 = 5'd5; y5 = 5'd5; start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_product5", 64'(product5), 64'd0);
    check("abort_busy5",    64'(busy5),    64'd0);
    check("abort_done5",    64'(done5),    64'd0);
    check("abort_product8", 64'(product8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_stays_idle", 64'(busy5), 64'd0);
    $display("dut5 reset abort: no done expected");
    run5(1'b1, 5'd3, 5'h1E, 10'h3FA);   // 3 * -2 = -6

    // Random WIDTH=8 sweep against an arithmetic model
    for (int i = 0; i < 100; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom);
      if (rsm) begin
        pa = int'($signed(ra));
        pb = int'($signed(rb));
      end else begin
        pa = int'(ra);
        pb = int'(rb);
      end
      run8(rsm, ra, rb, 16'(pa * pb));
    end

    repeat (3) @(negedge clk);
    check("q5_drained", 64'(q5.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
